sipo_deserializer: RTL and testbench

Serial-to-parallel receiver: the receiving end of the team's mux-fed shift-register serialisers (a register loading either shift data or parallel data). Accepts one qualified serial bit per clock and assembles WIDTH-bit words. Each completed word goes into a double-buffered output register, presented with a valid/ready handshake. Sits between a serial link or test pin and a byte-wide consumer.

---
 rtl/sipo_deserializer.sv | 141 ++++++++++++++
 tb/tb_sipo_deserializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: collects qualified serial bits into WIDTH-bit words and
// presents them through a double-buffered valid/ready output. Define PARITY_CHECK_EN for even-parity checking.
module sipo_deserializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             sin,
   input  logic             sin_valid,
   output logic [WIDTH-1:0] pout,
   output logic             pout_valid,
   input  logic             pout_ready,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

`ifdef PARITY_CHECK_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif
   localparam int CW = $clog2(FRAME);
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME - 1);

   logic [WIDTH-1:0] sh_reg, sh_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] pout_reg, pout_next;
   logic             pv_reg, pv_next;
   logic             ov_reg, ov_next;
   logic             busy_reg;
   logic [WIDTH-1:0] sh_shift;
   logic [WIDTH-1:0] word;
   logic             complete;

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign sh_shift = {sh_reg[WIDTH-2:0], sin};
      end else begin : g_lsb_first
         assign sh_shift = {sin, sh_reg[WIDTH-1:1]};
      end
   endgenerate

`ifdef PARITY_CHECK_EN
   // The final frame bit is parity only; the data bits are already all in sh_reg.
   assign word = sh_reg;
`else
   assign word = sh_shift;
`endif

   always_comb begin
      sh_next   = sh_reg;
      cnt_next  = cnt_reg;
      pout_next = pout_reg;
      pv_next   = pv_reg;
      ov_next   = ov_reg;
      complete  = 1'b0;
      if (sin_valid) begin
         if (cnt_reg == LAST_CNT) begin
            cnt_next = '0;
            complete = 1'b1;
         end else begin
            cnt_next = cnt_reg + 1'b1;
            sh_next  = sh_shift;
         end
      end
      if (complete) begin
         if (!pv_reg || pout_ready) begin
            pout_next = word;
            pv_next   = 1'b1;
         end else begin
            ov_next = 1'b1;
         end
      end else if (pv_reg && pout_ready) begin
         pv_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_reg   <= '0;
         cnt_reg  <= '0;
         pout_reg <= '0;
         pv_reg   <= 1'b0;
         ov_reg   <= 1'b0;
         busy_reg <= 1'b0;
      end else if (clr) begin
         sh_reg   <= '0;
         cnt_reg  <= '0;
         pout_reg <= '0;
         pv_reg   <= 1'b0;
         ov_reg   <= 1'b0;
         busy_reg <= 1'b0;
      end else begin
         sh_reg   <= sh_next;
         cnt_reg  <= cnt_next;
         pout_reg <= pout_next;
         pv_reg   <= pv_next;
         ov_reg   <= ov_next;
         busy_reg <= (cnt_next != '0);
      end
   end

`ifdef PARITY_CHECK_EN
   logic pe_reg, pe_next;

   // Status follows the word in pout: loaded with it, cleared when it is consumed.
   always_comb begin
      pe_next = pe_reg;
      if (complete) begin
         if (!pv_reg || pout_ready) begin
            pe_next = (^sh_reg) ^ sin;
         end
      end else if (pv_reg && pout_ready) begin
         pe_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pe_reg <= 1'b0;
      end else if (clr) begin
         pe_reg <= 1'b0;
      end else begin
         pe_reg <= pe_next;
      end
   end

   assign parity_err = pe_reg;
`else
   assign parity_err = 1'b0;
`endif

   assign pout       = pout_reg;
   assign pout_valid = pv_reg;
   assign overrun    = ov_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Randomised scoreboard bench for sipo_deserializer; drives one MSB-first and one
// LSB-first instance from the same serial stream and checks both against a frame-level model.
module tb_sipo_deserializer;
   localparam int W = 8;
`ifdef PARITY_CHECK_EN
   localparam int FRAME = W + 1;
`else
   localparam int FRAME = W;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic clr = 1'b0;
   logic sin = 1'b0;
   logic sin_valid = 1'b0;
   logic pout_ready = 1'b0;
   logic [W-1:0] pout_m, pout_l;
   logic pv_m, pv_l, busy_m, busy_l, ov_m, ov_l, pe_m, pe_l;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
      .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready),
      .busy(busy_m), .overrun(ov_m), .parity_err(pe_m)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
      .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready),
      .busy(busy_l), .overrun(ov_l), .parity_err(pe_l)
   );

   int checks = 0;
   int errors = 0;
   int words_seen = 0;
   bit rand_ready = 1'b0;

   typedef struct {
      logic [W-1:0] msb;
      logic [W-1:0] lsb;
      logic         pe;
   } exp_t;

   exp_t sb[$];
   bit   frame_bits[$];
   logic m_full, m_ov, m_pe;
   logic [W-1:0] m_msb, m_lsb;
   logic [W-1:0] w_msb, w_lsb;
   logic w_par;
   exp_t e_push, e_pop;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame bits are collected in a queue; a full frame becomes a word.
   always @(posedge clk or negedge rst) begin
      if (!rst || clr) begin
         frame_bits.delete();
         sb.delete();
         m_full = 1'b0;
         m_ov   = 1'b0;
         m_pe   = 1'b0;
         m_msb  = '0;
         m_lsb  = '0;
      end else begin
         if (sin_valid) frame_bits.push_back(sin);
         if (frame_bits.size() == FRAME) begin
            w_msb = '0;
            w_lsb = '0;
            w_par = 1'b0;
            for (int i = 0; i < W; i++) begin
               w_msb[W-1-i] = frame_bits[i];
               w_lsb[i]     = frame_bits[i];
            end
            for (int i = 0; i < FRAME; i++) w_par = w_par ^ frame_bits[i];
            frame_bits.delete();
            if (!m_full || pout_ready) begin
               m_full = 1'b1;
               m_msb  = w_msb;
               m_lsb  = w_lsb;
`ifdef PARITY_CHECK_EN
               m_pe   = w_par;
`endif
               e_push.msb = w_msb;
               e_push.lsb = w_lsb;
               e_push.pe  = m_pe;
               sb.push_back(e_push);
            end else begin
               m_ov = 1'b1;
            end
         end else if (m_full && pout_ready) begin
            m_full = 1'b0;
            m_pe   = 1'b0;
         end
      end
   end

   // Monitor: status every cycle, and a scoreboard pop on every handshake.
   always @(negedge clk) begin
      if (rst) begin
         chk("pout_valid_msb", 32'(pv_m), 32'(m_full));
         chk("pout_valid_lsb", 32'(pv_l), 32'(m_full));
         chk("pout_msb", 32'(pout_m), 32'(m_msb));
         chk("pout_lsb", 32'(pout_l), 32'(m_lsb));
         chk("busy_msb", 32'(busy_m), 32'(frame_bits.size() != 0));
         chk("busy_lsb", 32'(busy_l), 32'(frame_bits.size() != 0));
         chk("overrun_msb", 32'(ov_m), 32'(m_ov));
         chk("overrun_lsb", 32'(ov_l), 32'(m_ov));
         chk("parity_err_msb", 32'(pe_m), 32'(m_pe));
         chk("parity_err_lsb", 32'(pe_l), 32'(m_pe));
         if (pv_m && pout_ready && !clr) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got handshake of %0h expected no word at %0t", pout_m, $time);
            end else begin
               e_pop = sb.pop_front();
               words_seen++;
               chk("word_msb", 32'(pout_m), 32'(e_pop.msb));
               chk("word_lsb", 32'(pout_l), 32'(e_pop.lsb));
               chk("word_pe", 32'(pe_m), 32'(e_pop.pe));
               $display("word %0d: msb=%h lsb=%h pe=%b", words_seen, pout_m, pout_l, pe_m);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_ready) pout_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      sin = b;
      sin_valid = 1'b1;
      tick();
      sin_valid = 1'b0;
      sin = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] d, input int gap, input logic bad_par);
      $display("send %h gap %0d par %b", d, gap, (^d) ^ bad_par);
      for (int i = W - 1; i >= 0; i--) begin
         send_bit(d[i]);
         if (gap > 0) idle(gap);
      end
`ifdef PARITY_CHECK_EN
      send_bit((^d) ^ bad_par);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      idle(3);
      rst = 1'b1;
      idle(2);

      // Reset in the middle of a frame discards the partial word.
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      #2 rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(1);
      pout_ready = 1'b0;
      send_word(8'hA5, 0, 1'b0);
      idle(2);
      pout_ready = 1'b1;
      idle(2);

      send_word(8'hC0, 0, 1'b0);
      idle(2);

      send_word(8'h3C, 5, 1'b0);
      idle(2);

      // Overrun with the consumer stalled, then drain, then clear.
      pout_ready = 1'b0;
      send_word(8'h11, 0, 1'b0);
      send_word(8'h22, 0, 1'b0);
      idle(2);
      pout_ready = 1'b1;
      idle(3);
      pout_ready = 1'b0;
      idle(2);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      idle(2);

      pout_ready = 1'b1;
      send_word(8'hF0, 0, 1'b0);
      send_word(8'h0F, 0, 1'b0);
      send_word(8'hAA, 0, 1'b0);
      idle(2);

      // clr coinciding with a sampled bit drops that bit.
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      sin = 1'b1;
      sin_valid = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      sin_valid = 1'b0;
      send_word(8'h5A, 0, 1'b0);
      idle(2);

      pout_ready = 1'b0;
      send_word(8'h07, 0, 1'b0);
      idle(2);
      pout_ready = 1'b1;
      idle(1);
      pout_ready = 1'b0;
      send_word(8'h07, 0, 1'b1);
      idle(2);
      pout_ready = 1'b1;
      idle(2);

      rand_ready = 1'b1;
      repeat (40) begin
         send_word(W'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
      end
      rand_ready = 1'b0;
      pout_ready = 1'b1;
      idle(4);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
